// File: rtl/demux_pkg.sv
// Shared types for the demux feeder: channel select, FIFO entry layout, FSM states.
package demux_pkg;

    localparam int NUM_CH      = 4;
    localparam int FEED_DATA_W = 4;

    typedef logic [1:0] ch_sel_t;

    typedef struct packed {
        ch_sel_t                sel;
        logic [FEED_DATA_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic {IDLE, HOLD} feeder_state_t;

    // Round-robin successor; wraps after the last demux channel.
    function automatic ch_sel_t next_ch(ch_sel_t c);
        return (int'(c) == NUM_CH - 1) ? ch_sel_t'(0) : ch_sel_t'(c + 2'd1);
    endfunction

endpackage

// File: rtl/demux_feeder_sync_fifo.sv
// Count-based synchronous FIFO, no fall-through: head is read combinationally
// from storage, so a word written on one edge can be popped on the next at the earliest.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are ignored rather than corrupting state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset; occupancy decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/demux_feeder.sv
// Feeder for the 4-way demux: buffers {sel,data} words and holds each one on
// registered data/sel outputs for DWELL cycles, back-to-back while words remain.
module demux_feeder
    import demux_pkg::*;
#(
    parameter int DATA_W = FEED_DATA_W,
    parameter int DEPTH  = 4,
    parameter int DWELL  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [1:0]                 in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       rr_en,
    output logic [DATA_W-1:0]          data,
    output logic [1:0]                 sel,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int EW  = DATA_W + 2;
    localparam int DCW = $clog2(DWELL + 1);

    feeder_state_t     state_q, state_d;
    logic [DCW-1:0]    dwell_q, dwell_d;
    logic [DATA_W-1:0] data_q, data_d;
    ch_sel_t           sel_q, sel_d, rr_q, rr_d;
    logic              vld_q, vld_d;

    logic              full, empty, pop, load;
    logic [EW-1:0]     head;

    assign in_ready  = !full;
    assign data      = data_q;
    assign sel       = sel_q;
    assign out_valid = vld_q;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid && !full),
        .pop_i   (pop),
        .wdata_i ({in_sel, in_data}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Dwell FSM: load a word whenever the outputs are free, otherwise count down the hold.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        data_d  = data_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        rr_d    = rr_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: load = !empty;
            HOLD: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DCW'(1);
                end else if (!empty) begin
                    load = 1'b1;
                end else begin
                    // Leaving the outputs live with stale data would drive a demux channel.
                    state_d = IDLE;
                    data_d  = '0;
                    vld_d   = 1'b0;
                end
            end
        endcase
        if (load) begin
            pop     = 1'b1;
            state_d = HOLD;
            vld_d   = 1'b1;
            dwell_d = DCW'(DWELL - 1);
            data_d  = head[DATA_W-1:0];
            // data and sel update on the same edge so the demux never sees a mixed pair.
            if (rr_en) begin
                sel_d = rr_q;
                rr_d  = next_ch(rr_q);
            end else begin
                sel_d = ch_sel_t'(head[DATA_W +: 2]);
            end
        end
    end

    // Output and FSM registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dwell_q <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_demux_feeder.sv
// Bench for demux_feeder: three parameterisations share one stimulus stream and
// are each checked every cycle against a queue/schedule model.
module tb_demux_feeder;
    import demux_pkg::*;

    localparam int NI = 3;
    localparam int DEP [NI] = '{4, 8, 8};
    localparam int DWL [NI] = '{2, 1, 4};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] in_data = '0;
    logic [1:0] in_sel = '0;
    logic       in_valid = 1'b0;
    logic       rr_en = 1'b0;

    logic [3:0] d   [NI];
    logic [1:0] s   [NI];
    logic       ov  [NI];
    logic       rdy [NI];
    logic [2:0] cnt0;
    logic [3:0] cnt1, cnt2;

    always #5 clk = ~clk;

    demux_feeder #(.DATA_W(4), .DEPTH(4), .DWELL(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(rdy[0]), .rr_en(rr_en), .data(d[0]), .sel(s[0]), .out_valid(ov[0]), .count(cnt0));
    demux_feeder #(.DATA_W(4), .DEPTH(8), .DWELL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(rdy[1]), .rr_en(rr_en), .data(d[1]), .sel(s[1]), .out_valid(ov[1]), .count(cnt1));
    demux_feeder #(.DATA_W(4), .DEPTH(8), .DWELL(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(rdy[2]), .rr_en(rr_en), .data(d[2]), .sel(s[2]), .out_valid(ov[2]), .count(cnt2));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    endtask

    function automatic int cnt_of(int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Model: each instance has a queue of pending words and a "visible until
    // edge hold_end" schedule; a word may start at the first edge after it
    // was queued once the previous word's DWELL window has elapsed.
    fifo_entry_t mq [NI][$];
    int          hold_end [NI];
    int          m_rr [NI];
    logic [3:0]  m_data [NI];
    logic [1:0]  m_sel [NI];
    bit          m_vld [NI];
    int          cyc;

    always @(posedge clk or negedge rst_n) begin
        fifo_entry_t e;
        int pre;
        bit dpush;
        if (!rst_n) begin
            cyc = 0;
            for (int i = 0; i < NI; i++) begin
                mq[i].delete();
                hold_end[i] = 0;
                m_rr[i] = 0;
                m_data[i] = '0;
                m_sel[i] = '0;
                m_vld[i] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < NI; i++) begin
                pre = mq[i].size();
                dpush = in_valid && (pre < DEP[i]);
                if (pre > 0 && (!m_vld[i] || cyc >= hold_end[i])) begin
                    e = mq[i].pop_front();
                    m_data[i] = e.data;
                    if (rr_en) begin
                        m_sel[i] = 2'(m_rr[i]);
                        m_rr[i] = (m_rr[i] + 1) % 4;
                    end else begin
                        m_sel[i] = e.sel;
                    end
                    m_vld[i] = 1'b1;
                    hold_end[i] = cyc + DWL[i];
                end else if (m_vld[i] && cyc >= hold_end[i]) begin
                    m_vld[i] = 1'b0;
                    m_data[i] = '0;
                end
                if (dpush) begin
                    e.sel = in_sel;
                    e.data = in_data;
                    mq[i].push_back(e);
                end
            end
        end
    end

    bit         chk_on = 1'b0;
    bit         rec_on = 1'b0;
    logic [6:0] rec [$];

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d data", i), int'(d[i]), int'(m_data[i]));
                chk($sformatf("u%0d sel", i), int'(s[i]), int'(m_sel[i]));
                chk($sformatf("u%0d out_valid", i), int'(ov[i]), int'(m_vld[i]));
                chk($sformatf("u%0d count", i), cnt_of(i), mq[i].size());
                chk($sformatf("u%0d in_ready", i), int'(rdy[i]), int'(mq[i].size() < DEP[i]));
            end
        end
        if (rec_on) rec.push_back({ov[0], s[0], d[0]});
    end

    task automatic reset_literals(string tag);
        chk({tag, " data"}, int'(d[0]), 0);
        chk({tag, " sel"}, int'(s[0]), 0);
        chk({tag, " out_valid"}, int'(ov[0]), 0);
        chk({tag, " count"}, int'(cnt0), 0);
        chk({tag, " in_ready"}, int'(rdy[0]), 1);
    endtask

    initial begin
        int nv, first, last, k;
        bit hit;

        // Power-on reset, checked asynchronously.
        #2 rst_n = 1'b0;
        #1 reset_literals("por");
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single word, producer select.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'hA; in_sel = 2'd2; rr_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("single latency", int'(ov[0]), 0);
        repeat (2) begin
            @(negedge clk);
            chk("single data", int'(d[0]), 10);
            chk("single sel", int'(s[0]), 2);
            chk("single valid", int'(ov[0]), 1);
        end
        @(negedge clk);
        chk("single clear data", int'(d[0]), 0);
        chk("single clear valid", int'(ov[0]), 0);
        chk("single sel kept", int'(s[0]), 2);
        repeat (4) @(negedge clk);

        // Round-robin back-to-back: 5 words, sel 0,1,2,3,0, no gaps.
        rr_en = 1'b1;
        rec.delete();
        rec_on = 1'b1;
        for (int w = 0; w < 5; w++) begin
            in_valid = 1'b1; in_data = 4'(w + 1); in_sel = 2'd3;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rec_on = 1'b0;
        rr_en = 1'b0;
        nv = 0; first = -1; last = -1;
        for (int j = 0; j < rec.size(); j++) begin
            if (rec[j][6]) begin
                if (first < 0) first = j;
                last = j;
                chk("rr sel", int'(rec[j][5:4]), (nv / 2) % 4);
                chk("rr data", int'(rec[j][3:0]), nv / 2 + 1);
                nv++;
            end
        end
        chk("rr valid cycles", nv, 10);
        chk("rr contiguous span", last - first + 1, 10);
        repeat (4) @(negedge clk);

        // Fill u0 while it is holding; keep presenting while full.
        hit = 1'b0;
        k = 0;
        in_valid = 1'b1;
        while (!hit && k < 20) begin
            in_data = 4'($urandom); in_sel = 2'($urandom);
            @(negedge clk);
            hit = !rdy[0];
            k++;
        end
        chk("full reached", int'(hit), 1);
        chk("full count", int'(cnt0), 4);
        repeat (3) begin
            in_data = 4'($urandom); in_sel = 2'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        // DEPTH=8/DWELL=4 fills to 8 before in_ready drops; DWELL=1 keeps up.
        hit = 1'b0;
        k = 0;
        in_valid = 1'b1;
        while (!hit && k < 30) begin
            in_data = 4'($urandom); in_sel = 2'($urandom);
            @(negedge clk);
            chk("u1 keeps pace", int'(cnt1 <= 4'd1), 1);
            hit = !rdy[2];
            k++;
        end
        chk("u2 full reached", int'(hit), 1);
        chk("u2 full count", int'(cnt2), 8);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);

        // Reset mid-hold with three words queued behind the current one.
        for (int w = 0; w < 5; w++) begin
            in_valid = 1'b1; in_data = 4'(w + 3); in_sel = 2'(w);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre-reset count", int'(cnt0), 3);
        chk("pre-reset valid", int'(ov[0]), 1);
        #2 rst_n = 1'b0;
        #1 reset_literals("midhold");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            reset_literals("post-reset");
        end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data = 4'($urandom);
            in_sel = 2'($urandom);
            if ($urandom_range(0, 15) == 0) rr_en = ~rr_en;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("drained u0", int'(cnt0), 0);
        chk("drained u2", int'(cnt2), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
